// File: rtl/spek_mem_pkg.sv
// Shared definitions for the line-organised backing memory: FSM states, line geometry
// and the address-to-line-index mapping.
package spek_mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVICT_WR = 2'd1,
        WAIT     = 2'd2,
        RESP     = 2'd3
    } lm_state_t;

    localparam int unsigned LINE_BYTES = 64;
    localparam int unsigned LINE_OFF_W = 6;

    // Offset bits are dropped and upper bits masked off, so addresses wrap modulo the store.
    function automatic int unsigned line_index(input logic [63:0] addr,
                                               input int unsigned depth);
        logic [63:0] line_num;
        line_num = addr >> LINE_OFF_W;
        return 32'(line_num) & (depth - 1);
    endfunction

endpackage

// File: rtl/line_store.sv
// Single-port synchronous line RAM with write enable and a registered read port.
// Array contents are never reset; only the read data register is.
module line_store #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 512,
    parameter int unsigned AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/line_mem_ctl.sv
// Cache-side backing memory: serves line fills after a fixed latency and absorbs evictions.
// Optional fill/evict statistics counters are enabled by defining LINE_MEM_STATS_EN.
module line_mem_ctl
    import spek_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LINE_W      = 512,
    parameter int unsigned DEPTH_LINES = 256,
    parameter int unsigned LATENCY     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              i_evict,
    input  logic [ADDR_W-1:0] i_evict_addr,
    input  logic [LINE_W-1:0] i_evict_data,
    output logic [LINE_W-1:0] o_memory_line,
    output logic              o_memory_response,
    output logic              o_evict_ack,
    output logic              o_busy
`ifdef LINE_MEM_STATS_EN
    ,
    output logic [15:0]       o_fill_count,
    output logic [15:0]       o_evict_count
`endif
);

    localparam int unsigned IDX_W = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    lm_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
    logic [IDX_W-1:0]  evict_idx_q, evict_idx_d;
    logic [LINE_W-1:0] evict_data_q, evict_data_d;
    logic              resp_q, ack_q, busy_q;

    logic              st_we, st_re;
    logic [IDX_W-1:0]  st_addr;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        miss_idx_d   = miss_idx_q;
        evict_idx_d  = evict_idx_q;
        evict_data_d = evict_data_q;
        st_we        = 1'b0;
        st_re        = 1'b0;
        st_addr      = miss_idx_q;

        unique case (state_q)
            IDLE: begin
                // Eviction wins a tie so a same-line read observes the evicted data.
                if (i_evict) begin
                    state_d      = EVICT_WR;
                    evict_idx_d  = IDX_W'(line_index(64'(i_evict_addr), DEPTH_LINES));
                    evict_data_d = i_evict_data;
                    if (i_miss) begin
                        miss_idx_d = IDX_W'(line_index(64'(i_miss_addr), DEPTH_LINES));
                        pend_d     = 1'b1;
                    end
                end else if (i_miss) begin
                    state_d    = WAIT;
                    miss_idx_d = IDX_W'(line_index(64'(i_miss_addr), DEPTH_LINES));
                    cnt_d      = CNT_LOAD;
                end
            end
            EVICT_WR: begin
                st_we   = 1'b1;
                st_addr = evict_idx_q;
                pend_d  = 1'b0;
                if (pend_q) begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    st_re   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            miss_idx_q   <= '0;
            evict_idx_q  <= '0;
            evict_data_q <= '0;
            resp_q       <= 1'b0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            miss_idx_q   <= miss_idx_d;
            evict_idx_q  <= evict_idx_d;
            evict_data_q <= evict_data_d;
            // Pulses are registered off the next state so they line up with the state itself.
            resp_q       <= (state_d == RESP);
            ack_q        <= (state_d == EVICT_WR);
            busy_q       <= (state_d != IDLE);
        end
    end

    line_store #(
        .DEPTH (DEPTH_LINES),
        .WIDTH (LINE_W),
        .AW    (IDX_W)
    ) u_store (
        .clk   (clk),
        .rst   (rst),
        .we    (st_we),
        .re    (st_re),
        .addr  (st_addr),
        .wdata (evict_data_q),
        .rdata (o_memory_line)
    );

    assign o_memory_response = resp_q;
    assign o_evict_ack       = ack_q;
    assign o_busy            = busy_q;

`ifdef LINE_MEM_STATS_EN
    logic [15:0] fill_cnt_q, evict_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_cnt_q  <= '0;
            evict_cnt_q <= '0;
        end else begin
            if (state_d == RESP && fill_cnt_q != 16'hFFFF) begin
                fill_cnt_q <= fill_cnt_q + 16'd1;
            end
            if (state_d == EVICT_WR && evict_cnt_q != 16'hFFFF) begin
                evict_cnt_q <= evict_cnt_q + 16'd1;
            end
        end
    end

    assign o_fill_count  = fill_cnt_q;
    assign o_evict_count = evict_cnt_q;
`endif

endmodule

// File: tb/tb_line_mem_ctl.sv
// Self-checking bench for line_mem_ctl: vector table of evict/read pairs, a response
// scoreboard, and hand-written hold, back-to-back and reset-abort sequences.
module tb_line_mem_ctl;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned LINE_W      = 512;
    localparam int unsigned DEPTH_LINES = 256;
    localparam int unsigned LATENCY     = 4;

    logic              clk;
    logic              rst;
    logic              i_miss;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              i_evict;
    logic [ADDR_W-1:0] i_evict_addr;
    logic [LINE_W-1:0] i_evict_data;
    logic [LINE_W-1:0] o_memory_line;
    logic              o_memory_response;
    logic              o_evict_ack;
    logic              o_busy;
`ifdef LINE_MEM_STATS_EN
    logic [15:0]       o_fill_count;
    logic [15:0]       o_evict_count;
`endif

    line_mem_ctl #(
        .ADDR_W      (ADDR_W),
        .LINE_W      (LINE_W),
        .DEPTH_LINES (DEPTH_LINES),
        .LATENCY     (LATENCY)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_miss            (i_miss),
        .i_miss_addr       (i_miss_addr),
        .i_evict           (i_evict),
        .i_evict_addr      (i_evict_addr),
        .i_evict_data      (i_evict_data),
        .o_memory_line     (o_memory_line),
        .o_memory_response (o_memory_response),
        .o_evict_ack       (o_evict_ack),
        .o_busy            (o_busy)
`ifdef LINE_MEM_STATS_EN
        ,
        .o_fill_count      (o_fill_count),
        .o_evict_count     (o_evict_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int resp_cnt = 0;
    int last_resp_cyc = 0;
    int prev_resp_cyc = 0;
    logic [LINE_W-1:0] exp_q [$];

    typedef struct {
        logic [ADDR_W-1:0] ev_addr;
        logic [LINE_W-1:0] ev_data;
        logic [ADDR_W-1:0] rd_addr;
        bit                together;
        logic [LINE_W-1:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [LINE_W-1:0] act,
                                  input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] seed);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < 16; i++) begin
            l[i*32 +: 32] = seed ^ (32'(i) * 32'h0101_0101);
        end
        return l;
    endfunction

    // Scoreboard: every response pops the oldest expected line.
    always begin
        @(posedge clk);
        #1;
        if (o_memory_response) begin
            resp_cnt++;
            prev_resp_cyc = last_resp_cyc;
            last_resp_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got response=1 expected none");
            end else begin
                check("resp_data", o_memory_line, exp_q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (o_busy) check_int("idle_timeout", 1, 0);
    endtask

    // Cycle numbers are counted from the accepting edge (=1).
    task automatic run_txn(input bit do_ev, input logic [ADDR_W-1:0] ev_addr,
                           input logic [LINE_W-1:0] ev_data, input bit do_rd,
                           input logic [ADDR_W-1:0] rd_addr, input logic [LINE_W-1:0] exp_data,
                           input int exp_ack, input int exp_resp, input string tag);
        int ack_at = 0;
        int resp_at = 0;
        int n = 0;
        wait_idle();
        if (do_rd) exp_q.push_back(exp_data);
        i_evict      = do_ev;
        i_evict_addr = ev_addr;
        i_evict_data = ev_data;
        i_miss       = do_rd;
        i_miss_addr  = rd_addr;
        while (n < 40 && ((do_ev && ack_at == 0) || (do_rd && resp_at == 0))) begin
            @(posedge clk);
            #1;
            n++;
            if (o_evict_ack && ack_at == 0) begin
                ack_at  = n;
                i_evict = 1'b0;
            end
            if (o_memory_response && resp_at == 0) begin
                resp_at = n;
                i_miss  = 1'b0;
            end
        end
        i_evict = 1'b0;
        i_miss  = 1'b0;
        if (do_ev) check_int({tag, "_ack_cyc"}, ack_at, exp_ack);
        if (do_rd) check_int({tag, "_resp_cyc"}, resp_at, exp_resp);
    endtask

    initial begin
        logic [LINE_W-1:0] line_f;
        logic [LINE_W-1:0] line_g;
        int n;
        int ack_at;
        int resp_at;
        int resp_before;

        vecs[0] = '{32'h0000_0040, {16{32'hDEAD_BEEF}}, 32'h0000_0044, 1'b0,
                    {16{32'hDEAD_BEEF}}};
        vecs[1] = '{32'h0000_0080, mk_line(32'hA000_0000), 32'h0000_0080, 1'b1,
                    mk_line(32'hA000_0000)};
        vecs[2] = '{32'h0000_0000, mk_line(32'hB000_0000), 32'h0000_4000, 1'b0,
                    mk_line(32'hB000_0000)};
        vecs[3] = '{32'h0000_3FC0, mk_line(32'hC000_0000), 32'hFFFF_FFC0, 1'b1,
                    mk_line(32'hC000_0000)};
        vecs[4] = '{32'h0000_0040, mk_line(32'hD000_0000), 32'h0000_0080, 1'b1,
                    mk_line(32'hA000_0000)};
        vecs[5] = '{32'h0000_1040, mk_line(32'hE000_0000), 32'h0000_107F, 1'b0,
                    mk_line(32'hE000_0000)};
        line_f = mk_line(32'hF000_0000);
        line_g = mk_line(32'h6000_0000);

        rst          = 1'b0;
        i_miss       = 1'b0;
        i_miss_addr  = '0;
        i_evict      = 1'b0;
        i_evict_addr = '0;
        i_evict_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_int("rst_resp", int'(o_memory_response), 0);
        check_int("rst_ack", int'(o_evict_ack), 0);
        check_int("rst_busy", int'(o_busy), 0);
        check("rst_line", o_memory_line, '0);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].together) begin
                run_txn(1'b1, vecs[i].ev_addr, vecs[i].ev_data, 1'b1, vecs[i].rd_addr,
                        vecs[i].exp_data, 1, LATENCY + 2, $sformatf("vec%0d_both", i));
            end else begin
                run_txn(1'b1, vecs[i].ev_addr, vecs[i].ev_data, 1'b0, '0, '0, 1, 0,
                        $sformatf("vec%0d_ev", i));
                run_txn(1'b0, '0, '0, 1'b1, vecs[i].rd_addr, vecs[i].exp_data, 0, LATENCY + 1,
                        $sformatf("vec%0d_rd", i));
            end
        end

        // Back-to-back reads: second accepted in the IDLE cycle right after the response.
        run_txn(1'b0, '0, '0, 1'b1, 32'h0000_0080, mk_line(32'hA000_0000), 0, LATENCY + 1, "b2b0");
        run_txn(1'b0, '0, '0, 1'b1, 32'h0000_3FC0, mk_line(32'hC000_0000), 0, LATENCY + 1, "b2b1");
        repeat (2) @(posedge clk);
        #1;
        check_int("b2b_spacing", last_resp_cyc - prev_resp_cyc, LATENCY + 2);

        // Eviction raised during WAIT is held off until the IDLE after RESP.
        run_txn(1'b1, 32'h0000_0100, line_f, 1'b0, '0, '0, 1, 0, "hold_pre");
        wait_idle();
        exp_q.push_back(line_f);
        i_miss_addr = 32'h0000_0100;
        i_miss      = 1'b1;
        @(posedge clk);
        #1;
        i_evict_addr = 32'h0000_0200;
        i_evict_data = line_g;
        i_evict      = 1'b1;
        n       = 1;
        ack_at  = 0;
        resp_at = 0;
        while (n < 40 && (ack_at == 0 || resp_at == 0)) begin
            @(posedge clk);
            #1;
            n++;
            if (o_evict_ack && ack_at == 0) begin
                ack_at  = n;
                i_evict = 1'b0;
            end
            if (o_memory_response && resp_at == 0) begin
                resp_at = n;
                i_miss  = 1'b0;
            end
        end
        i_evict = 1'b0;
        i_miss  = 1'b0;
        check_int("hold_resp_cyc", resp_at, LATENCY + 1);
        check_int("hold_ack_gap", ack_at - resp_at, 2);
        run_txn(1'b0, '0, '0, 1'b1, 32'h0000_0200, line_g, 0, LATENCY + 1, "hold_rd");

        // Reset during WAIT aborts the read with no response afterwards.
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        resp_before = resp_cnt;
        i_miss_addr = 32'h0000_0080;
        i_miss      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_int("pre_rst_busy", int'(o_busy), 1);
        rst    = 1'b0;
        i_miss = 1'b0;
        #1;
        check_int("rst_async_busy", int'(o_busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_int("abort_no_resp", resp_cnt - resp_before, 0);
        check_int("abort_idle", int'(o_busy), 0);
        check_int("abort_no_ack", int'(o_evict_ack), 0);

`ifdef LINE_MEM_STATS_EN
        check_int("stats_fill_rst", int'(o_fill_count), 0);
        for (int i = 0; i < 3; i++) begin
            run_txn(1'b0, '0, '0, 1'b1, 32'h0000_0080, mk_line(32'hA000_0000), 0, LATENCY + 1,
                    $sformatf("stats_rd%0d", i));
        end
        check_int("stats_fill", int'(o_fill_count), 3);
        check_int("stats_evict", int'(o_evict_count), 0);
`endif

        check_int("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
